// File: rtl/qgx_stim_drv_if.sv
// qgx_stim_drv_if: beat bus between the stimulus driver and the module under test.
// The master (driver) owns valid/sz/vb/zvf; the slave (sink) owns ready.
interface qgx_stim_drv_if #(
  parameter int VB_W = 72
);
  logic            valid;
  logic            ready;
  logic            sz;
  logic [VB_W-1:0] vb;
  logic [3:0]      zvf;

  modport master (output valid, output sz, output vb, output zvf, input ready);
  modport slave  (input valid, input sz, input vb, input zvf, output ready);
endinterface

// File: rtl/qgx_stim_drv.sv
// qgx_stim_drv: seeded xorshift64 stimulus source for qgx-style fuzz modules.
// Emits NUM_BEATS beats over a valid/ready handshake, stepping the xorshift
// state once per accepted beat, then reports the final state on o_seed_after.
// Optional macro QGX_STIM_XZ_EN: sz becomes 4-state, decoded from x[1:0]
// (00->0, 01->1, 10->z, 11->x). Without it sz is simply x[0].
module qgx_stim_drv #(
  parameter logic [63:0] SEED_A    = 64'd16013029700436987217,
  parameter logic [63:0] SEED_B    = 64'd3128299129089410139,
  parameter int          NUM_BEATS = 16,
  parameter int          VB_W      = 72
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [63:0]          i_seed_in,
  qgx_stim_drv_if.master       bus,
  output logic [15:0]          o_beat_cnt,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [63:0]          o_seed_after,
  output logic [63:0]          o_seed_b_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LAST_BEAT = 16'(NUM_BEATS - 1);

  state_t          r_state;
  state_t          w_nextState;
  logic [63:0]     r_x;
  logic [63:0]     w_xStep;
  logic [15:0]     r_beatCnt;
  logic            r_valid;
  logic            r_sz;
  logic [VB_W-1:0] r_vb;
  logic [3:0]      r_zvf;
  logic [63:0]     r_seedAfter;
  logic            w_accept;
  logic            w_lastBeat;

  function automatic logic [63:0] xorshiftStep(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [VB_W-1:0] vbOf(input logic [63:0] v);
    logic [127:0] t;
    t = {v, v};
    return t[VB_W-1:0];
  endfunction

`ifdef QGX_STIM_XZ_EN
  function automatic logic szOf(input logic [63:0] v);
    logic s;
    case (v[1:0])
      2'b00:   s = 1'b0;
      2'b01:   s = 1'b1;
      2'b10:   s = 1'bz;
      default: s = 1'bx;
    endcase
    return s;
  endfunction
`else
  function automatic logic szOf(input logic [63:0] v);
    return v[0];
  endfunction
`endif

  assign w_xStep    = xorshiftStep(r_x);
  assign w_accept   = (r_state == RUN) && r_valid && bus.ready;
  assign w_lastBeat = w_accept && (r_beatCnt == LAST_BEAT);

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; abort overrides every transition, including start in IDLE.
  always_comb begin
    w_nextState = r_state;
    if (i_abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_start) w_nextState = LOAD;
        LOAD:    w_nextState = RUN;
        RUN:     if (w_lastBeat) w_nextState = DONE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Datapath: seed load, beat presentation and stepping on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_beatCnt   <= '0;
      r_valid     <= 1'b0;
      r_sz        <= 1'b0;
      r_vb        <= '0;
      r_zvf       <= '0;
      r_seedAfter <= '0;
    end else if (i_abort) begin
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_x       <= (i_seed_in == 64'd0) ? SEED_A : i_seed_in;
          r_beatCnt <= '0;
          r_valid   <= 1'b0;
        end
        RUN: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_sz    <= szOf(r_x);
            r_vb    <= vbOf(r_x);
            r_zvf   <= r_x[63:60];
          end else if (bus.ready) begin
            r_x       <= w_xStep;
            r_beatCnt <= r_beatCnt + 16'd1;
            if (r_beatCnt == LAST_BEAT) begin
              r_valid     <= 1'b0;
              r_seedAfter <= w_xStep;
            end else begin
              r_sz  <= szOf(w_xStep);
              r_vb  <= vbOf(w_xStep);
              r_zvf <= w_xStep[63:60];
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid    = r_valid;
  assign bus.sz       = r_sz;
  assign bus.vb       = r_vb;
  assign bus.zvf      = r_zvf;
  assign o_beat_cnt   = r_beatCnt;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_seed_after = r_seedAfter;
  assign o_seed_b_out = SEED_B;

endmodule

// File: tb/tb_qgx_stim_drv.sv
// tb_qgx_stim_drv: directed bench for qgx_stim_drv built with NUM_BEATS=4.
module tb_qgx_stim_drv;

  localparam int          VB_W      = 72;
  localparam int          NUM_BEATS = 4;
  localparam logic [63:0] SEED_A    = 64'd16013029700436987217;
  localparam logic [63:0] SEED_B    = 64'd3128299129089410139;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [63:0] seedIn;
  logic [15:0] beatCnt;
  logic        busy;
  logic        done;
  logic [63:0] seedAfter;
  logic [63:0] seedBOut;

  int checkCount = 0;
  int errorCount = 0;

  qgx_stim_drv_if #(.VB_W(VB_W)) bus ();

  qgx_stim_drv #(
    .SEED_A(SEED_A), .SEED_B(SEED_B), .NUM_BEATS(NUM_BEATS), .VB_W(VB_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_seed_in(seedIn), .bus(bus), .o_beat_cnt(beatCnt), .o_busy(busy),
    .o_done(done), .o_seed_after(seedAfter), .o_seed_b_out(seedBOut)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] xsStep(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [63:0] xsSteps(input logic [63:0] v, input int n);
    logic [63:0] t;
    t = v;
    for (int i = 0; i < n; i++) t = xsStep(t);
    return t;
  endfunction

  function automatic logic [127:0] vbOf(input logic [63:0] v);
    logic [127:0] t;
    t = {v, v};
    return {56'd0, t[VB_W-1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start with the given seed and advances to the first valid beat.
  task automatic applyStimulus(input logic [63:0] seed);
    seedIn = seed;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
  endtask

  task automatic drainRun();
    for (int i = 0; i < 20 && busy; i++) tick();
    checkOutput("drain_idle", busy, 1'b0);
  endtask

  int          validCnt;
  int          doneCnt;
  logic [63:0] capSeedAfter;
  logic [127:0] heldVb;
  logic        expSz;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    seedIn = 64'd0;
    bus.ready = 1'b1;
    #12;
    checkOutput("rst_valid", bus.valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_cnt", beatCnt, 16'd0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_seed_after", seedAfter, 64'd0);
    checkOutput("rst_vb", bus.vb, 128'd0);
    checkOutput("rst_sz", bus.sz, 1'b0);
    checkOutput("rst_seed_b", seedBOut, SEED_B);
    tick();
    rst_n = 1'b1;
    tick();

    // Latency and first beats with seed 1
    seedIn = 64'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checkOutput("lat_k_valid", bus.valid, 1'b0);
    checkOutput("lat_k_busy", busy, 1'b1);
    tick();
    checkOutput("lat_k1_valid", bus.valid, 1'b0);
    tick();
    checkOutput("lat_k2_valid", bus.valid, 1'b1);
    checkOutput("s1_b0_vb", bus.vb, vbOf(64'd1));
    checkOutput("s1_b0_vb_lo", bus.vb[63:0], 64'd1);
    checkOutput("s1_b0_sz", bus.sz, 1'b1);
    checkOutput("s1_b0_zvf", bus.zvf, 4'h0);
    checkOutput("s1_b0_cnt", beatCnt, 16'd0);
    tick();
    checkOutput("s1_b1_vb_lo", bus.vb[63:0], 64'h40822041);
    checkOutput("s1_b1_sz", bus.sz, 1'b1);
    checkOutput("s1_b1_cnt", beatCnt, 16'd1);
    tick();
    tick();
    checkOutput("s1_b3_cnt", beatCnt, 16'd3);
    tick();
    checkOutput("s1_done", done, 1'b1);
    checkOutput("s1_done_valid", bus.valid, 1'b0);
    checkOutput("s1_done_cnt", beatCnt, 16'd4);
    checkOutput("s1_seed_after", seedAfter, xsSteps(64'd1, 4));
    tick();
    checkOutput("s1_post_done", done, 1'b0);
    checkOutput("s1_post_busy", busy, 1'b0);
    checkOutput("s1_post_cnt", beatCnt, 16'd4);

    // Full run with seed 0 selecting SEED_A
    seedIn = 64'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    validCnt = 0;
    doneCnt  = 0;
    capSeedAfter = 64'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.valid) begin
        if (validCnt == 0) checkOutput("sA_b0_vb", bus.vb, vbOf(SEED_A));
        validCnt++;
      end
      if (done) begin
        doneCnt++;
        capSeedAfter = seedAfter;
      end
    end
    checkOutput("sA_valid_cycles", validCnt, 4);
    checkOutput("sA_done_pulses", doneCnt, 1);
    checkOutput("sA_cnt", beatCnt, 16'd4);
    checkOutput("sA_seed_after", capSeedAfter, xsSteps(SEED_A, 4));

    // Back-pressure with ready pattern 1,0,0,1, then abort at beat 2
    applyStimulus(64'd5);
    checkOutput("bp_b0_vb", bus.vb, vbOf(64'd5));
    tick();
    checkOutput("bp_b1_cnt", beatCnt, 16'd1);
    bus.ready = 1'b0;
    heldVb = bus.vb;
    tick();
    checkOutput("bp_hold1_vb", bus.vb, vbOf(xsSteps(64'd5, 1)));
    checkOutput("bp_hold1_cnt", beatCnt, 16'd1);
    checkOutput("bp_hold1_valid", bus.valid, 1'b1);
    tick();
    checkOutput("bp_hold2_vb", bus.vb, heldVb);
    checkOutput("bp_hold2_cnt", beatCnt, 16'd1);
    bus.ready = 1'b1;
    tick();
    checkOutput("bp_b2_cnt", beatCnt, 16'd2);
    checkOutput("bp_b2_vb", bus.vb, vbOf(xsSteps(64'd5, 2)));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_valid", bus.valid, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_seed_after", seedAfter, xsSteps(SEED_A, 4));
    tick();
    checkOutput("abort_no_done", done, 1'b0);
    applyStimulus(64'd1);
    checkOutput("restart_b0_vb", bus.vb, vbOf(64'd1));
    checkOutput("restart_cnt", beatCnt, 16'd0);
    drainRun();

    // start and abort together in IDLE keep the block idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", busy, 1'b0);
    tick();
    checkOutput("start_abort_busy2", busy, 1'b0);

    // Asynchronous reset in the middle of a run
    applyStimulus(64'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", bus.valid, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_cnt", beatCnt, 16'd0);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_seed_b", seedBOut, SEED_B);
    tick();
    rst_n = 1'b1;
    tick();

    // sz decoding for seeds 2 and 3
    applyStimulus(64'd2);
`ifdef QGX_STIM_XZ_EN
    expSz = 1'bz;
`else
    expSz = 1'b0;
`endif
    checkOutput("sz_seed2", bus.sz, expSz);
    drainRun();
    applyStimulus(64'd3);
`ifdef QGX_STIM_XZ_EN
    expSz = 1'bx;
`else
    expSz = 1'b1;
`endif
    checkOutput("sz_seed3", bus.sz, expSz);
    drainRun();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/qgx_stim_drv.md
Name: qgx_stim_drv

Overview:
- Seeded stimulus source that drives the input side of the qgx-style fuzz modules: scalar sz, wide packed bus vb, small vector zvf.
- Steps a 64-bit xorshift state once per accepted beat. Emits NUM_BEATS beats over a valid/ready handshake, then reports the final ("seed after") state.
- Sits between the test harness and the module under test; drives exactly the nets the module consumes.

Parameters:
- SEED_A, 64'd16013029700436987217, default xorshift seed; used when seed_in == 0.
- SEED_B, 64'd3128299129089410139, secondary seed; passed through unchanged to seed_b_out.
- NUM_BEATS, 16, beats per run; legal range 1..65535.
- VB_W, 72, width of the vb bus; legal range 1..128.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled in IDLE only.
- abort  input  1  synchronous return to IDLE from any state.
- seed_in  input  64  run seed; 0 selects SEED_A.
- ready  input  1  sink accepts the current beat.
- valid  output  1  sz/vb/zvf hold a beat.
- sz  output  1  beat scalar.
- vb  output  VB_W  beat wide bus.
- zvf  output  4  beat small vector.
- beat_cnt  output  16  beats accepted in the current run.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse at end of run.
- seed_after  output  64  xorshift state at end of run.
- seed_b_out  output  64  constant SEED_B.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE; valid=0, sz=0, vb=0, zvf=0, beat_cnt=0, busy=0, done=0, seed_after=0, xorshift state x=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if start is high at a clock edge, go to LOAD.
- LOAD: for one cycle, set x to seed_in (or SEED_A when seed_in == 0) and beat_cnt to 0, then go to RUN.
- RUN: valid=1. Outputs are registered from the current x:
  - sz = x[0]
  - zvf = x[63:60]
  - vb = {x, x}[VB_W-1:0]
- Latency: start sampled at edge k gives valid=1 after edge k+2.
- Handshake: while valid && !ready, sz/vb/zvf/valid hold stable. On valid && ready:
  - x steps: x ^= x<<13; x ^= x>>7; x ^= x<<17 (all 64-bit, truncating).
  - beat_cnt increments.
  - Next-beat outputs appear the following cycle, with no bubble.
- Last beat: when the beat accepted is number NUM_BEATS (beat_cnt == NUM_BEATS-1 before the increment), go to DONE. valid drops after that edge.
- DONE: for one cycle, done=1, seed_after = x (already stepped past the last beat), valid=0. Then go to IDLE. beat_cnt holds NUM_BEATS until the next LOAD.
- abort: takes priority over every transition. Next state is IDLE, valid=0 after the edge, done not pulsed, seed_after unchanged.
- start outside IDLE is ignored. start and abort high together in IDLE: stay in IDLE.
- rst_n asserted mid-run: all outputs immediately return to their reset values; no done pulse.
- seed_b_out is constant and unaffected by reset or FSM state.
- busy = (state != IDLE).

Optional Feature:
- Macro: QGX_STIM_XZ_EN.
- Defined: sz is 4-state, taken from x[1:0]: 2'b00 gives 0, 2'b01 gives 1, 2'b10 gives z, 2'b11 gives x. Stable while held. Reset value 0.
- Undefined: sz = x[0]; sz only ever carries 0 or 1.

Test Plan:
- Reset, then seed_in=1, start pulse, ready=1 → valid rises 2 cycles after start. Beat 0: sz=1, zvf=0, vb[63:0]=1. Beat 1: vb[63:0]=64'h40822041, sz=1.
- seed_in=0, NUM_BEATS=4, ready=1 → beat 0 vb[63:0]=SEED_A; exactly 4 valid cycles; done pulses once; beat_cnt=4; seed_after equals the 4th xorshift step of SEED_A (checked against a reference model).
- ready toggled 1,0,0,1 during RUN → outputs stable across the ready=0 cycles; beat_cnt advances only on the two ready=1 cycles.
- abort asserted at beat 2 → valid=0 next cycle; no done; busy=0; a fresh start with seed_in=1 restarts from beat 0 = 1.
- rst_n pulsed low mid-run → valid, busy, beat_cnt all 0 asynchronously; seed_b_out still equals SEED_B.
- With QGX_STIM_XZ_EN and seed_in=64'h2 → beat 0 sz === 1'bz. With seed_in=64'h3 → sz === 1'bx. Without the macro, the same seeds give sz=0 and sz=1.
